tb_align_collector: RTL and testbench

//  Downstream of the traceback stage. Captures the reverse-order (bottom-right to top-left)

---
 rtl/tb_align_collector_if.sv | 31 +++
 rtl/tb_align_collector.sv | 256 +++++++++++++++++++++++++
 tb/tb_tb_align_collector.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tb_align_collector_if.sv
// Stream bundle between the traceback stage, the alignment collector and the
// downstream consumer. The traceback side (start/pair/finish) flows into the
// collector; the replay side (out_*) flows out of it.
//
// Handshake: out_valid/out_ready follow strict valid/ready rules. A transfer
// happens on a rising clk edge where out_valid && out_ready. Once out_valid is
// high, out_r/out_q/out_last/out_valid stay unchanged until that transfer.
// out_ready may be driven freely and never depends on out_valid.
interface tb_align_collector_if;
  logic       start_traceback;
  logic [2:0] tb_r;
  logic [2:0] tb_q;
  logic       tb_finish;
  logic [2:0] out_r;
  logic [2:0] out_q;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  // Environment side: feeds traceback pairs and consumes the replay stream
  modport master (
    output start_traceback, tb_r, tb_q, tb_finish, out_ready,
    input  out_r, out_q, out_valid, out_last
  );

  // Collector side
  modport slave (
    input  start_traceback, tb_r, tb_q, tb_finish, out_ready,
    output out_r, out_q, out_valid, out_last
  );
endinterface

// File: rtl/tb_align_collector.sv
// Alignment collector placed after the traceback stage.
// Traceback emits base pairs from the bottom-right cell back to the top-left
// cell. This block stacks them in a LIFO, then replays them in forward order
// over a valid/ready stream. It also reports the alignment length and a
// sticky overflow flag.
// Optional build macro TBC_STATS_EN adds the match/mismatch/gap counters and
// their output ports.
module tb_align_collector #(
  parameter int L     = 8,       // subsequence length in bases
  parameter int DEPTH = 2 * L,   // LIFO entries; worst-case path length
  parameter int CW    = 5        // counter width, holds 0..DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tb_align_collector_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        aln_len,
  output logic                 overflow,
  output logic [1:0]           dbg_state
`ifdef TBC_STATS_EN
  ,
  output logic [CW-1:0]        match_cnt,
  output logic [CW-1:0]        mismatch_cnt,
  output logic [CW-1:0]        gap_cnt
`endif
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] NO_DATA = 3'b111;
  localparam logic [2:0] GAP     = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [5:0]      r_mem [DEPTH];
  logic [CW-1:0]   r_ptr;          // entries currently stacked
  logic [CW-1:0]   r_aln_len;
  logic            r_overflow;
  logic [2:0]      r_out_r;
  logic [2:0]      r_out_q;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_done;

  logic [5:0]      w_pair;
  logic            w_pair_present;
  logic            w_full;
  logic            w_capturing;
  logic            w_push_req;
  logic            w_push_ok;
  logic            w_drop;
  logic [CW-1:0]   w_cnt_after;
  logic [5:0]      w_top_after;
  logic [5:0]      w_next_top;
  logic            w_clear;
  logic            w_abort;
  logic            w_finish;
  logic            w_handshake;

  // A pair carries data when at least one field is not the no-data code.
  assign w_pair         = {bus.tb_r, bus.tb_q};
  assign w_pair_present = (bus.tb_r != NO_DATA) || (bus.tb_q != NO_DATA);
  assign w_full         = (r_ptr == CW'(DEPTH));

  // Pushes happen only in CAPTURE while start is still held; an abort cycle
  // stores nothing.
  assign w_capturing    = (r_state == S_CAPTURE) && bus.start_traceback;
  assign w_push_req     = w_capturing && w_pair_present;
  assign w_push_ok      = w_push_req && !w_full;
  assign w_drop         = w_push_req && w_full;
  assign w_cnt_after    = r_ptr + CW'(w_push_ok);

  // Top of stack as it will look after this cycle's push, used to preload the
  // output register on the finish edge so out_valid rises one cycle later.
  assign w_top_after    = w_push_ok ? w_pair : r_mem[AW'(r_ptr - CW'(1))];
  // Entry below the one currently presented, loaded on a non-final pop.
  assign w_next_top     = r_mem[AW'(r_ptr - CW'(2))];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and one-cycle control strobes
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_abort      = 1'b0;
    w_finish     = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_traceback) begin
          w_next_state = S_CAPTURE;
          w_clear      = 1'b1;
        end
      end
      S_CAPTURE: begin
        // Dropping start wins over a finish in the same cycle.
        if (!bus.start_traceback) begin
          w_next_state = S_IDLE;
          w_abort      = 1'b1;
        end else if (bus.tb_finish) begin
          w_finish     = 1'b1;
          w_next_state = (w_cnt_after == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // start_traceback is ignored here; the drain always completes.
        if (r_out_valid && bus.out_ready) begin
          w_handshake = 1'b1;
          if (r_out_last) begin
            w_next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Wait for start to drop so held finish/pair inputs are not re-captured.
        if (!bus.start_traceback) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // LIFO storage; contents are only meaningful below r_ptr
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[AW'(r_ptr)] <= w_pair;
    end
  end

  // Stack pointer, alignment length and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_aln_len  <= '0;
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_ptr      <= '0;
      r_aln_len  <= '0;
      r_overflow <= 1'b0;
    end else if (w_abort) begin
      r_ptr      <= '0;
    end else begin
      // Push and pop live in different states, so they never coincide.
      if (w_push_ok) begin
        r_ptr     <= r_ptr + CW'(1);
        r_aln_len <= r_aln_len + CW'(1);
      end else if (w_handshake) begin
        r_ptr     <= r_ptr - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Registered replay stream and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_r     <= NO_DATA;
      r_out_q     <= NO_DATA;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_finish) begin
        if (w_cnt_after != '0) begin
          {r_out_r, r_out_q} <= w_top_after;
          r_out_valid        <= 1'b1;
          r_out_last         <= (w_cnt_after == CW'(1));
        end else begin
          // Empty alignment: nothing to replay, report completion directly.
          r_done <= 1'b1;
        end
      end else if (w_handshake) begin
        if (r_out_last) begin
          r_out_r     <= NO_DATA;
          r_out_q     <= NO_DATA;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_done      <= 1'b1;
        end else begin
          {r_out_r, r_out_q} <= w_next_top;
          r_out_last         <= (r_ptr == CW'(2));
        end
      end
    end
  end

`ifdef TBC_STATS_EN
  logic          w_is_gap;
  logic          w_is_match;
  logic [CW-1:0] r_match_cnt;
  logic [CW-1:0] r_mismatch_cnt;
  logic [CW-1:0] r_gap_cnt;

  assign w_is_gap   = (bus.tb_r == GAP) || (bus.tb_q == GAP);
  assign w_is_match = !w_is_gap && (bus.tb_r == bus.tb_q);

  // Pair classification counters; dropped pairs are not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_gap_cnt      <= '0;
    end else if (w_clear) begin
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_gap_cnt      <= '0;
    end else if (w_push_ok) begin
      if (w_is_gap) begin
        r_gap_cnt <= r_gap_cnt + CW'(1);
      end else if (w_is_match) begin
        r_match_cnt <= r_match_cnt + CW'(1);
      end else begin
        r_mismatch_cnt <= r_mismatch_cnt + CW'(1);
      end
    end
  end

  assign match_cnt    = r_match_cnt;
  assign mismatch_cnt = r_mismatch_cnt;
  assign gap_cnt      = r_gap_cnt;
`else
  // Gap code only matters for the optional statistics.
  logic [2:0] w_gap_unused;
  assign w_gap_unused = GAP;
`endif

  assign bus.out_r     = r_out_r;
  assign bus.out_q     = r_out_q;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign busy          = (r_state == S_CAPTURE) || (r_state == S_DRAIN);
  assign done          = r_done;
  assign aln_len       = r_aln_len;
  assign overflow      = r_overflow;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_tb_align_collector.sv
// Bench for tb_align_collector: table of whole-alignment cases, hand-written
// abort and reset-during-drain sequences, then randomized alignments checked
// against a queue-based reference of the collector's behaviour.
module tb_tb_align_collector;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tb_align_collector_if bus();
  logic          busy;
  logic          done;
  logic          overflow;
  logic [CW-1:0] aln_len;
  logic [1:0]    dbg_state;
`ifdef TBC_STATS_EN
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] mismatch_cnt;
  logic [CW-1:0] gap_cnt;
`endif

  tb_align_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .aln_len   (aln_len),
    .overflow  (overflow),
    .dbg_state (dbg_state)
`ifdef TBC_STATS_EN
    ,
    .match_cnt    (match_cnt),
    .mismatch_cnt (mismatch_cnt),
    .gap_cnt      (gap_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    string             name;
    int                n;
    logic [23:0][5:0]  p;      // {r,q} per cycle, last one carries tb_finish
    int                rmode;  // 0 always ready, 1 pattern 1,0,0, 2 random
    int                e_len;
    logic              e_ovf;
    logic [5:0]        e_first;
    int                e_m;
    int                e_mm;
    int                e_g;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.start_traceback = 1'b0;
    bus.tb_r            = 3'b111;
    bus.tb_q            = 3'b111;
    bus.tb_finish       = 1'b0;
    bus.out_ready       = 1'b0;
  endtask

  function automatic logic [2:0] pick();
    int v;
    v = $urandom_range(0, 5);
    return (v == 5) ? 3'b111 : 3'(v);
  endfunction

  function automatic logic [23:0][5:0] ramp(input int n);
    logic [23:0][5:0] p;
    p = '0;
    for (int i = 0; i < n; i++) p[i] = {3'(i % 4), 3'((i + 1) % 4)};
    return p;
  endfunction

  // Reference: data pairs are kept in arrival order up to DEPTH, later ones
  // are dropped; classification counts only the kept pairs.
  function automatic void model_calc(input int n, input logic [23:0][5:0] p,
                                     output int len, output logic ovf,
                                     output logic [5:0] first,
                                     output int m, output int mm, output int g);
    int         seen;
    logic [2:0] r;
    logic [2:0] q;
    seen = 0; len = 0; m = 0; mm = 0; g = 0; first = 6'o77;
    for (int k = 0; k < n; k++) begin
      if (p[k] != 6'o77) begin
        seen++;
        if (seen <= DEPTH) begin
          len++;
          first = p[k];
          r = p[k][5:3];
          q = p[k][2:0];
          if (r == 3'b100 || q == 3'b100) g++;
          else if (r == q) m++;
          else mm++;
        end
      end
    end
    ovf = (seen > DEPTH);
  endfunction

  // One full alignment: capture n pairs, drain with the chosen ready style,
  // then check completion and held results.
  task automatic run_case(input string name, input int n, input logic [23:0][5:0] p,
                          input int rmode, input int e_len, input logic e_ovf,
                          input logic [5:0] e_first, input int e_m, input int e_mm,
                          input int e_g);
    int         cyc;
    logic       stalled;
    logic       rdy;
    logic [7:0] held;
    exp_q.delete();
    for (int k = 0; k < n; k++)
      if (p[k] != 6'o77 && exp_q.size() < DEPTH) exp_q.push_back(p[k]);

    @(negedge clk);
    bus.start_traceback = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({name, "_cap_busy"}, busy, 1);
      chk({name, "_cap_novalid"}, bus.out_valid, 0);
      bus.tb_r      = p[k][5:3];
      bus.tb_q      = p[k][2:0];
      bus.tb_finish = (k == n - 1);
    end

    // tb_finish and the final pair stay held through drain and done.
    stalled = 1'b0;
    held    = '0;
    cyc     = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk({name, "_valid_rise"}, bus.out_valid, 1);
        chk({name, "_first_out"}, {bus.out_r, bus.out_q}, e_first);
        chk({name, "_len_early"}, aln_len, e_len);
      end
      if (stalled)
        chk({name, "_hold"}, {bus.out_valid, bus.out_last, bus.out_r, bus.out_q}, held);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        chk({name, "_pair"}, {bus.out_r, bus.out_q}, exp_q[$]);
        chk({name, "_last"}, bus.out_last, (exp_q.size() == 1));
        void'(exp_q.pop_back());
        stalled = 1'b0;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        held    = {bus.out_valid, bus.out_last, bus.out_r, bus.out_q};
      end else begin
        stalled = 1'b0;
      end
      cyc++;
    end
    chk({name, "_drain_left"}, exp_q.size(), 0);

    @(negedge clk);
    chk({name, "_done"}, done, 1);
    chk({name, "_end_out"}, {bus.out_valid, bus.out_last, bus.out_r, bus.out_q}, 8'b00_111_111);
    chk({name, "_end_busy"}, busy, 0);
    @(negedge clk);
    chk({name, "_done_1cyc"}, done, 0);
    @(negedge clk);
    chk({name, "_no_recap"}, {busy, bus.out_valid}, 0);
    idle_inputs();
    @(negedge clk);
    chk({name, "_idle"}, dbg_state, 0);
    chk({name, "_len"}, aln_len, e_len);
    chk({name, "_ovf"}, overflow, e_ovf);
`ifdef TBC_STATS_EN
    chk({name, "_match"}, match_cnt, e_m);
    chk({name, "_mismatch"}, mismatch_cnt, e_mm);
    chk({name, "_gap"}, gap_cnt, e_g);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0][5:0] p;
    logic [23:0][5:0] basic;
    int               len;
    int               m;
    int               mm;
    int               g;
    logic             ovf;
    logic [5:0]       first;

    basic = '0;
    basic[0] = 6'o11; basic[1] = 6'o23; basic[2] = 6'o42; basic[3] = 6'o00;
    vecs[0] = '{"basic",    4, basic, 0, 4, 1'b0, 6'o00, 2, 1, 1};
    vecs[1] = '{"backpr",   4, basic, 1, 4, 1'b0, 6'o00, 2, 1, 1};
    p = '0;
    p[0] = 6'o77; p[1] = 6'o33; p[2] = 6'o72; p[3] = 6'o44; p[4] = 6'o77;
    vecs[2] = '{"nodata",   5, p, 0, 3, 1'b0, 6'o44, 1, 1, 1};
    p = '0;
    p[0] = 6'o77;
    vecs[3] = '{"empty",    1, p, 0, 0, 1'b0, 6'o77, 0, 0, 0};
    p = '0;
    p[0] = 6'o22;
    vecs[4] = '{"single",   1, p, 0, 1, 1'b0, 6'o22, 1, 0, 0};
    vecs[5] = '{"overflow", 17, ramp(17), 0, 16, 1'b1, 6'o30, 0, 16, 0};
    vecs[6] = '{"full",     16, ramp(16), 1, 16, 1'b0, 6'o30, 0, 16, 0};

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", dbg_state, 0);
    chk("rst_out", {bus.out_valid, bus.out_last, bus.out_r, bus.out_q}, 8'b00_111_111);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len", aln_len, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    // Table-driven alignments
    for (int i = 0; i < 7; i++)
      run_case(vecs[i].name, vecs[i].n, vecs[i].p, vecs[i].rmode, vecs[i].e_len,
               vecs[i].e_ovf, vecs[i].e_first, vecs[i].e_m, vecs[i].e_mm, vecs[i].e_g);

    // Abort: start drops together with a finish; nothing is replayed
    @(negedge clk);
    bus.start_traceback = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.tb_r = 3'(k + 1);
      bus.tb_q = 3'(k + 1);
    end
    @(negedge clk);
    bus.start_traceback = 1'b0;
    bus.tb_finish       = 1'b1;
    bus.tb_r            = 3'd5;
    bus.tb_q            = 3'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_novalid", bus.out_valid, 0);
      chk("abort_nodone", done, 0);
      chk("abort_idle", dbg_state, 0);
    end
    idle_inputs();
    run_case("after_abort", 4, basic, 0, 4, 1'b0, 6'o00, 2, 1, 1);

    // Reset after two handshakes in DRAIN
    @(negedge clk);
    bus.start_traceback = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.tb_r      = basic[k][5:3];
      bus.tb_q      = basic[k][2:0];
      bus.tb_finish = (k == 3);
    end
    @(negedge clk);
    chk("rstd_hs1", {bus.out_valid, bus.out_r, bus.out_q}, {1'b1, 6'o00});
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rstd_hs2", {bus.out_valid, bus.out_r, bus.out_q}, {1'b1, 6'o42});
    @(negedge clk);
    chk("rstd_third", {bus.out_valid, bus.out_r, bus.out_q}, {1'b1, 6'o23});
    rst_n = 1'b0;
    #1;
    chk("rstd_out", {bus.out_valid, bus.out_last, bus.out_r, bus.out_q}, 8'b00_111_111);
    chk("rstd_flags", {busy, done, overflow}, 0);
    chk("rstd_len", aln_len, 0);
    chk("rstd_state", dbg_state, 0);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstd_nodone", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstd_after", {dbg_state, done, bus.out_valid}, 0);

    // Randomized alignments against the reference
    for (int it = 0; it < 40; it++) begin
      int n;
      n = $urandom_range(1, 20);
      p = '0;
      for (int k = 0; k < n; k++)
        p[k] = ($urandom_range(0, 3) == 0) ? 6'o77 : {pick(), pick()};
      model_calc(n, p, len, ovf, first, m, mm, g);
      run_case("rand", n, p, 2, len, ovf, first, m, mm, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
